// File: rtl/rsa_decryptor.sv
// RSA decryption M = C^d mod n using left-to-right square-and-multiply.
// Each modular product is formed by a 16-cycle interleaved shift-add reduction.
module rsa_decryptor (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ciphertext,
    input  logic [15:0] private_exp,
    input  logic [15:0] modulus,
    output logic [15:0] plaintext,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, DONE} state_t;

    state_t      state;
    logic [15:0] c_r;
    logic [15:0] d_r;
    logic [15:0] n_r;
    logic [15:0] result;
    logic [16:0] acc;
    logic [3:0]  idx;
    logic [3:0]  cnt;

    logic [15:0] mul_a;
    logic [16:0] n_ext;
    logic [16:0] dbl;
    logic [16:0] dbl_r;
    logic [16:0] add;
    logic [16:0] acc_next;

    // One step of a*b mod n; b is always the running result, MSB first.
    always_comb begin
        n_ext    = {1'b0, n_r};
        mul_a    = (state == MUL) ? c_r : result;
        dbl      = acc << 1;
        dbl_r    = (dbl >= n_ext) ? dbl - n_ext : dbl;
        add      = dbl_r + {1'b0, mul_a};
        acc_next = dbl_r;
        if (result[cnt])
            acc_next = (add >= n_ext) ? add - n_ext : add;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            c_r       <= '0;
            d_r       <= '0;
            n_r       <= '0;
            result    <= '0;
            acc       <= '0;
            idx       <= '0;
            cnt       <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        c_r    <= ciphertext;
                        d_r    <= private_exp;
                        n_r    <= modulus;
                        result <= 16'd1;
                        idx    <= 4'd15;
                        cnt    <= 4'd15;
                        acc    <= '0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= 4'd15;
                    acc <= '0;
                    if (n_r < 16'd2 || c_r >= n_r) begin
                        plaintext <= '0;
                        error     <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= SQR;
                    end
                end
                SQR, MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        acc    <= '0;
                        result <= acc_next[15:0];
                        if (state == SQR && d_r[idx]) begin
                            state <= MUL;
                        end else if (idx == 4'd0) begin
                            plaintext <= acc_next[15:0];
                            error     <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            idx   <= idx - 4'd1;
                            state <= SQR;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decryptor.sv
// Self-checking bench for rsa_decryptor: vector table, scoreboard queue,
// and hand sequences for reset, start toggling and start hold.
module tb_rsa_decryptor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ciphertext;
    logic [15:0] private_exp;
    logic [15:0] modulus;
    logic [15:0] plaintext;
    logic        busy;
    logic        done;
    logic        error;

    rsa_decryptor dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .private_exp(private_exp),
        .modulus    (modulus),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] d;
        logic [15:0] n;
        logic [15:0] pt;
        logic        err;
        int          lat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain square-and-multiply with wide integer arithmetic.
    function automatic vec_t model(input logic [15:0] c, input logic [15:0] d,
                                   input logic [15:0] n);
        vec_t   v;
        longint r;
        int     w;
        v.c = c;
        v.d = d;
        v.n = n;
        if (n < 2 || c >= n) begin
            v.pt  = 16'd0;
            v.err = 1'b1;
            v.lat = 1;
            return v;
        end
        r = 1;
        w = 0;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % longint'(n);
            if (d[i]) begin
                r = (r * longint'(c)) % longint'(n);
                w++;
            end
        end
        v.pt  = r[15:0];
        v.err = 1'b0;
        v.lat = 1 + 16 * (16 + w);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input bit toggle, input string tag);
        vec_t e;
        int   edges;
        bit   busy_ok;
        @(negedge clk);
        ciphertext  = v.c;
        private_exp = v.d;
        modulus     = v.n;
        start       = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        ciphertext  = 16'($urandom);
        private_exp = 16'($urandom);
        modulus     = 16'($urandom);
        edges   = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 1200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (toggle) start = edges[0];
            @(posedge clk);
            #1;
            edges++;
        end
        e = sb.pop_front();
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " latency"}, edges, e.lat);
        chk({tag, " plaintext"}, {16'd0, plaintext}, {16'd0, e.pt});
        chk({tag, " error"}, {31'd0, error}, {31'd0, e.err});
        chk({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        if (!toggle) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                #1;
                chk({tag, " done_hold"}, {31'd0, done}, 32'd1);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " pt_held"}, {16'd0, plaintext}, {16'd0, e.pt});
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{16'd2790,  16'd2753,  16'd3233,  16'd65,    1'b0, 337};
        tbl[1] = '{16'd4,     16'd13,    16'd497,   16'd445,   1'b0, 305};
        tbl[2] = '{16'd1234,  16'd0,     16'd3233,  16'd1,     1'b0, 257};
        tbl[3] = '{16'd3233,  16'd77,    16'd3233,  16'd0,     1'b1, 1};
        tbl[4] = '{16'd0,     16'd5,     16'd1,     16'd0,     1'b1, 1};
        tbl[5] = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b1, 1};
        tbl[6] = '{16'd0,     16'd5,     16'd7,     16'd0,     1'b0, 289};
        tbl[7] = '{16'd6,     16'd1,     16'd7,     16'd6,     1'b0, 273};
        tbl[8] = '{16'd65534, 16'hFFFF,  16'd65535, 16'd65534, 1'b0, 513};
        tbl[9] = '{16'd1,     16'hFFFF,  16'd2,     16'd1,     1'b0, 513};

        reset       = 1'b1;
        start       = 1'b0;
        ciphertext  = '0;
        private_exp = '0;
        modulus     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst plaintext", {16'd0, plaintext}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            logic [15:0] n;
            n = 16'($urandom_range(65535, 2));
            v = model(16'($urandom_range(int'(n) - 1, 0)), 16'($urandom), n);
            run_op(v, 1'b0, $sformatf("rnd%0d", i));
        end
        v = model(16'd12345, 16'h8001, 16'd65521);
        run_op(v, 1'b0, "mdl");

        // Reset in the middle of a long run, then restart.
        @(negedge clk);
        ciphertext  = 16'd2790;
        private_exp = 16'd2753;
        modulus     = 16'd3233;
        start       = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst plaintext", {16'd0, plaintext}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        run_op(tbl[0], 1'b0, "restart");

        // Reset wins over start on the same edge.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_prio idle", {31'd0, busy}, 32'd0);

        // Start toggling while busy must not restart the operation.
        run_op(tbl[1], 1'b1, "toggle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
